// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  // Reserved MODE encodings fall back to one-shot.
  function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
    return (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/cpu_timer_if.sv
// Data-memory port between the bridge/pipeline (master) and the timer (slave).
interface cpu_timer_if #(
  parameter int DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;
  logic              irq;

  modport master (
    output sel, we, addr, wd,
    input  rd, irq
  );

  modport slave (
    input  sel, we, addr, wd,
    output rd, irq
  );
endinterface

// File: rtl/cpu_timer.sv
// Programmable down-counter timer with one-shot / auto-reload modes and a
// level interrupt; register file, FSM and counter share one clock domain.
module cpu_timer
  import timer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  cpu_timer_if.slave bus
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] r_count;
  logic              r_flag;
  state_e            r_state;

  logic [1:0]        w_idx;
  logic              w_wr_ctrl;
  logic              w_wr_preset;
  logic              w_en;
  logic              w_reload;
  logic              w_fsm_flag_set;
  logic              w_fsm_flag_clr;
  logic              w_fsm_en_clr;
  logic [DATA_W-1:0] w_rd;
  logic              w_unused_addr;

  assign w_idx         = bus.addr[3:2];
  assign w_unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
  assign w_en          = r_ctrl[CTRL_EN];
  assign w_reload      = is_reload(r_ctrl);

  // Bus write decode and FSM side-effect strobes on the control registers.
  always_comb begin
    w_wr_ctrl      = 1'b0;
    w_wr_preset    = 1'b0;
    w_fsm_flag_set = 1'b0;
    w_fsm_flag_clr = 1'b0;
    w_fsm_en_clr   = 1'b0;
    if (bus.sel && bus.we) begin
      w_wr_ctrl   = (w_idx == REG_CTRL);
      w_wr_preset = (w_idx == REG_PRESET);
    end else begin
      w_wr_ctrl   = 1'b0;
      w_wr_preset = 1'b0;
    end
    case (r_state)
      CNT: begin
        if (w_en && (r_count <= DATA_W'(1))) begin
          w_fsm_flag_set = 1'b1;
        end else begin
          w_fsm_flag_set = 1'b0;
        end
      end
      INT: begin
        // Auto-reload drops the flag on leaving INT, giving a one-cycle pulse.
        w_fsm_flag_clr = w_reload;
        w_fsm_en_clr   = w_en && !w_reload;
      end
      default: begin
        w_fsm_flag_set = 1'b0;
        w_fsm_flag_clr = 1'b0;
        w_fsm_en_clr   = 1'b0;
      end
    endcase
  end

  // Control state machine and the down counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_en) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!w_en) begin
            r_state <= IDLE;
          end else begin
            r_count <= r_preset;
            r_state <= CNT;
          end
        end
        CNT: begin
          if (!w_en) begin
            r_state <= IDLE;
          end else if (r_count > DATA_W'(1)) begin
            r_count <= r_count - DATA_W'(1);
          end else begin
            r_count <= {DATA_W{1'b0}};
            r_state <= INT;
          end
        end
        INT: begin
          if (!w_en) begin
            r_state <= IDLE;
          end else if (w_reload) begin
            r_state <= LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Register file and irq flag; CPU writes beat the FSM, FSM flag set beats CPU clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= {CTRL_W{1'b0}};
      r_preset <= {DATA_W{1'b0}};
      r_flag   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= bus.wd[CTRL_W-1:0];
      end else if (w_fsm_en_clr) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= bus.wd;
      end

      if (w_fsm_flag_set) begin
        r_flag <= 1'b1;
      end else if (w_wr_ctrl || w_wr_preset || w_fsm_flag_clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  // Read mux; independent of sel so the bridge can sample at any time.
  always_comb begin
    case (w_idx)
      REG_CTRL:   w_rd = {{(DATA_W-CTRL_W){1'b0}}, r_ctrl};
      REG_PRESET: w_rd = r_preset;
      REG_COUNT:  w_rd = r_count;
      default:    w_rd = {DATA_W{1'b0}};
    endcase
  end

  assign bus.rd  = w_rd;
  assign bus.irq = r_ctrl[CTRL_IM] & r_flag;

endmodule

// File: tb/tb_cpu_timer.sv
// Directed self-checking bench for cpu_timer.
module tb_cpu_timer;
  import timer_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_timer_if #(.DATA_W(DATA_W)) bus ();

  cpu_timer #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    tick();
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
  endtask

  task automatic rdr(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    n_checks++;
    if (dut.r_state !== IDLE) begin
      $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
      n_fail++;
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      $display("FAIL reset_irq: got %b expected 0", bus.irq);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      rdr(32'(i * 4), v);
      n_checks++;
      if (v !== 32'h0) begin
        $display("FAIL reset_rd%0d: got %h expected 00000000", i, v);
        n_fail++;
      end
    end
    wr(32'h0, 32'hFFFF_FFFF);
    rdr(32'h0, v);
    n_checks++;
    if (v !== 32'h0000_000F) begin
      $display("FAIL ctrl_mask: got %h expected 0000000f", v);
      n_fail++;
    end
    wr(32'h0, 32'h0);
    tick(2);
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    tick(2);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd5) begin
      $display("FAIL os_count_e2: got %0d expected 5", v);
      n_fail++;
    end
    tick(4);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd1 || bus.irq !== 1'b0) begin
      $display("FAIL os_count_e6: got count %0d irq %b expected 1 irq 0", v, bus.irq);
      n_fail++;
    end
    tick();
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd0 || bus.irq !== 1'b1) begin
      $display("FAIL os_irq_e7: got count %0d irq %b expected 0 irq 1", v, bus.irq);
      n_fail++;
    end
    tick();
    rdr(32'h0, v);
    n_checks++;
    if (v !== 32'h8) begin
      $display("FAIL os_en_clr: got ctrl %h expected 8", v);
      n_fail++;
    end
    tick(3);
    n_checks++;
    if (bus.irq !== 1'b1 || dut.r_state !== IDLE) begin
      $display("FAIL os_irq_hold: got irq %b state %0d expected 1 / IDLE", bus.irq, dut.r_state);
      n_fail++;
    end
    wr(32'h0, 32'h8);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      $display("FAIL os_irq_clr: got %b expected 0", bus.irq);
      n_fail++;
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 1) begin
        exp_cnt = 32'd0;
        exp_irq = 1'b0;
      end else begin
        p = (e - 2) % 5;
        exp_cnt = (p == 0) ? 32'd3 : (p == 1) ? 32'd2 : (p == 2) ? 32'd1 : 32'd0;
        exp_irq = (p == 3);
      end
      rdr(32'h8, v);
      n_checks++;
      if (v !== exp_cnt || bus.irq !== exp_irq) begin
        $display("FAIL ar_e%0d: got count %0d irq %b expected %0d irq %b", e, v, bus.irq, exp_cnt, exp_irq);
        n_fail++;
      end
    end
    wr(32'h0, 32'h0);
    tick(3);
  endtask

  task automatic test_freeze();
    logic [31:0] v;
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    tick(2);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd10) begin
      $display("FAIL fz_load: got %0d expected 10", v);
      n_fail++;
    end
    tick(3);
    wr(32'h0, 32'h8);
    for (int i = 0; i < 5; i++) begin
      rdr(32'h8, v);
      n_checks++;
      if (v !== 32'd6 || bus.irq !== 1'b0) begin
        $display("FAIL fz_hold%0d: got count %0d irq %b expected 6 irq 0", i, v, bus.irq);
        n_fail++;
      end
      tick();
    end
    wr(32'h0, 32'h9);
    tick();
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd6 || dut.r_state !== LOAD) begin
      $display("FAIL fz_reen_e1: got count %0d state %0d expected 6 / LOAD", v, dut.r_state);
      n_fail++;
    end
    tick();
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd10) begin
      $display("FAIL fz_reload: got %0d expected 10", v);
      n_fail++;
    end
    wr(32'h0, 32'h0);
    tick(3);
  endtask

  task automatic test_zero_preset();
    logic [31:0] v;
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    tick(2);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      $display("FAIL p0_e2: got irq %b expected 0", bus.irq);
      n_fail++;
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1 || dut.r_state !== INT) begin
      $display("FAIL p0_e3: got irq %b state %0d expected 1 / INT", bus.irq, dut.r_state);
      n_fail++;
    end
    wr(32'h8, 32'h55);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd0 || bus.irq !== 1'b1) begin
      $display("FAIL count_ro: got count %h irq %b expected 0 irq 1", v, bus.irq);
      n_fail++;
    end
    wr(32'hC, 32'hFF);
    rdr(32'hC, v);
    n_checks++;
    if (v !== 32'd0) begin
      $display("FAIL reg3: got %h expected 0", v);
      n_fail++;
    end
    wr(32'h0, 32'h8);
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h9);
    tick(2);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd1 || bus.irq !== 1'b0) begin
      $display("FAIL p1_e2: got count %0d irq %b expected 1 irq 0", v, bus.irq);
      n_fail++;
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1) begin
      $display("FAIL p1_e3: got irq %b expected 1", bus.irq);
      n_fail++;
    end
    wr(32'h0, 32'h0);
    tick(2);
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    wr(32'h4, 32'd6);
    wr(32'h0, 32'h9);
    tick(4);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd4) begin
      $display("FAIL rm_pre: got %0d expected 4", v);
      n_fail++;
    end
    reset    = 1'b1;
    bus.sel  = 1'b1;
    bus.we   = 1'b1;
    bus.addr = 32'h0;
    bus.wd   = 32'hF;
    tick();
    reset   = 1'b0;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdr(32'(i * 4), v);
      n_checks++;
      if (v !== 32'd0) begin
        $display("FAIL rm_reg%0d: got %h expected 0", i, v);
        n_fail++;
      end
    end
    n_checks++;
    if (dut.r_state !== IDLE || bus.irq !== 1'b0) begin
      $display("FAIL rm_state: got state %0d irq %b expected IDLE / 0", dut.r_state, bus.irq);
      n_fail++;
    end
    tick(2);
    rdr(32'h8, v);
    n_checks++;
    if (v !== 32'd0 || dut.r_state !== IDLE) begin
      $display("FAIL rm_after: got count %0d state %0d expected 0 / IDLE", v, dut.r_state);
      n_fail++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 32'h0;
    bus.wd   = 32'h0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_freeze();
    test_zero_preset();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
